// File: rtl/sig_loader.sv
// sig_loader: buffers a word-streamed signature, checks frame length and starts the verifier;
// defining SIG_WEIGHT_CHECK_EN also rejects frames whose Hamming weight exceeds W_MAX.
module sig_loader #(
   parameter int SIG_LEN = 1024,
   parameter int WORD_W = 32,
   parameter int W_MAX = 256,
   localparam int NWORDS = SIG_LEN / WORD_W,
   localparam int AW = $clog2(NWORDS),
   localparam int CW = $clog2(SIG_LEN + 1)
) (
   input  logic              clk,
   input  logic              rst_b,
   input  logic              in_valid,
   output logic              in_ready,
   input  logic [WORD_W-1:0] in_data,
   input  logic              in_last,
   output logic              start,
   input  logic              ver_finish,
   input  logic [AW-1:0]     rd_addr,
   output logic [WORD_W-1:0] rd_data,
   output logic [CW-1:0]     sig_weight,
   output logic              load_err
);
   typedef enum logic [2:0] {IDLE, LOAD, CHECK, START, WAIT, ERR} state_t;
`ifdef SIG_WEIGHT_CHECK_EN
   localparam bit WCHK = 1'b1;
`else
   localparam bit WCHK = 1'b0;
`endif
   state_t state, state_nxt;
   logic [WORD_W-1:0] mem [NWORDS];
   logic [AW:0] count;
   logic [CW-1:0] pc;
   logic xfer, last_word;
   assign in_ready = !rst_b && (state == IDLE || state == LOAD);
   assign xfer = in_valid && in_ready;
   assign last_word = count == (AW + 1)'(NWORDS - 1);
   assign start = state == START;
   assign load_err = state == ERR;
   always_comb begin
      pc = '0;
      for (int i = 0; i < WORD_W; i++) pc = pc + CW'(in_data[i]);
   end
   // count is zero in IDLE, so IDLE and LOAD share one word-acceptance rule
   always_comb begin
      state_nxt = state;
      case (state)
         IDLE, LOAD: state_nxt = !xfer ? state :
                                 (in_last && last_word) ? CHECK :
                                 (in_last || last_word) ? ERR : LOAD;
         CHECK:      state_nxt = (WCHK && int'(sig_weight) > W_MAX) ? ERR : START;
         START:      state_nxt = WAIT;
         WAIT:       state_nxt = ver_finish ? IDLE : WAIT;
         default:    state_nxt = IDLE;
      endcase
   end
   always_ff @(posedge clk) begin
      if (rst_b) begin
         state <= IDLE;
         count <= '0;
         sig_weight <= '0;
         rd_data <= '0;
      end else begin
         state <= state_nxt;
         rd_data <= mem[rd_addr];
         if (xfer) begin
            count <= count + 1'b1;
            sig_weight <= sig_weight + pc;
         end else if (load_err || (state == WAIT && ver_finish)) begin
            count <= '0;
            sig_weight <= '0;
         end
      end
   end
   always_ff @(posedge clk)
      if (xfer) mem[count[AW-1:0]] <= in_data;
endmodule
